cluster_expander: RTL and testbench



---
 rtl/cluster_expander_pkg.sv | 28 ++
 rtl/cluster_seg_mask.sv | 30 +++
 rtl/cluster_expander.sv | 104 ++++++++++
 tb/tb_cluster_expander.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cluster_expander_pkg.sv
// rtl/cluster_expander_pkg.sv - shared constants and types for the cluster expander
package cluster_expander_pkg;

  localparam int MXSEGS  = 12;
  localparam int SEGSIZE = 64;
  localparam int NSTRIPS = MXSEGS * SEGSIZE;
  localparam int ADRB    = 10;
  localparam int CNTB    = 3;
  localparam int NCLB    = 5;
  localparam int SEGB    = 4;

  localparam logic [NCLB-1:0] MXCLUSTERS  = 5'd16;
  localparam logic [ADRB-1:0] INVALID_ADR = 10'd1023;
  localparam logic [ADRB-1:0] ADR_LIMIT   = 10'd768;

  // One extra bit so adr+cnt past strip 767 cannot wrap.
  typedef logic [ADRB:0] strip_t;

  typedef struct packed {
    logic [ADRB-1:0] adr;
    logic [CNTB-1:0] cnt;
  } cluster_word_t;

  function automatic logic adr_ok(input logic [ADRB-1:0] adr);
    return (adr < ADR_LIMIT) && (adr != INVALID_ADR);
  endfunction

endpackage

// File: rtl/cluster_seg_mask.sv
// rtl/cluster_seg_mask.sv - window mask of one strip segment for a cluster adr/cnt
module cluster_seg_mask
  import cluster_expander_pkg::*;
(
  input  logic [SEGB-1:0]    seg_idx,
  input  logic [ADRB-1:0]    adr,
  input  logic [CNTB-1:0]    cnt,
  output logic [SEGSIZE-1:0] mask
);

  strip_t base;
  strip_t lo;
  strip_t hi;
  strip_t strip;

  assign base = strip_t'(seg_idx) * strip_t'(SEGSIZE);
  assign lo   = strip_t'(adr);
  assign hi   = strip_t'(adr) + strip_t'(cnt);

  // Strips never exceed 767, so a window running past the end clips by itself.
  always_comb begin
    mask  = '0;
    strip = '0;
    for (int i = 0; i < SEGSIZE; i++) begin
      strip   = base + strip_t'(i);
      mask[i] = (strip >= lo) && (strip <= hi);
    end
  end

endmodule

// File: rtl/cluster_expander.sv
// rtl/cluster_expander.sv - rebuilds the 768-strip bitmap from cluster words; CLUSTER_OVERLAP_DETECT_EN adds overlap_err
module cluster_expander
  import cluster_expander_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_clock,
  input  logic               cluster_valid,
  input  logic [ADRB-1:0]    cluster_adr,
  input  logic [CNTB-1:0]    cluster_cnt,
  output logic [NSTRIPS-1:0] vpfs_out,
  output logic               vpfs_valid,
  output logic               frame_overflow,
`ifdef CLUSTER_OVERLAP_DETECT_EN
  output logic               overlap_err,
`endif
  output logic [NCLB-1:0]    frame_nclusters
);

  logic [1:0]         fc_samples;
  logic               frame_edge;
  logic               s1_valid;
  logic               s1_edge;
  cluster_word_t      s1_word;
  logic [NSTRIPS-1:0] mask;
  logic [NSTRIPS-1:0] accum;
  logic [NCLB-1:0]    nclus;
  logic               ovf_flag;
  logic               s1_ok;
  logic               room;
`ifdef CLUSTER_OVERLAP_DETECT_EN
  logic               ovl_flag;
`endif

  assign frame_edge = (fc_samples == 2'b01);
  assign s1_ok      = s1_valid && adr_ok(s1_word.adr);
  assign room       = (nclus < MXCLUSTERS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fc_samples <= 2'b00;
      s1_valid   <= 1'b0;
      s1_edge    <= 1'b0;
      s1_word    <= '0;
    end else begin
      fc_samples <= {fc_samples[0], frame_clock};
      s1_valid   <= cluster_valid;
      s1_edge    <= frame_edge;
      s1_word    <= {cluster_adr, cluster_cnt};
    end
  end

  for (genvar s = 0; s < MXSEGS; s++) begin : g_seg
    cluster_seg_mask u_seg (
      .seg_idx (SEGB'(s)),
      .adr     (s1_word.adr),
      .cnt     (s1_word.cnt),
      .mask    (mask[s*SEGSIZE +: SEGSIZE])
    );
  end

  // A cluster riding the swap cycle opens the new frame's accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      accum           <= '0;
      nclus           <= '0;
      ovf_flag        <= 1'b0;
      vpfs_out        <= '0;
      vpfs_valid      <= 1'b0;
      frame_overflow  <= 1'b0;
      frame_nclusters <= '0;
`ifdef CLUSTER_OVERLAP_DETECT_EN
      ovl_flag        <= 1'b0;
      overlap_err     <= 1'b0;
`endif
    end else if (s1_edge) begin
      vpfs_out        <= accum;
      vpfs_valid      <= 1'b1;
      frame_overflow  <= ovf_flag;
      frame_nclusters <= nclus;
      accum           <= s1_ok ? mask : '0;
      nclus           <= s1_ok ? NCLB'(1) : '0;
      ovf_flag        <= 1'b0;
`ifdef CLUSTER_OVERLAP_DETECT_EN
      overlap_err     <= ovl_flag;
      ovl_flag        <= 1'b0;
`endif
    end else begin
      vpfs_valid <= 1'b0;
      if (s1_ok) begin
        if (room) begin
          accum <= accum | mask;
          nclus <= nclus + NCLB'(1);
`ifdef CLUSTER_OVERLAP_DETECT_EN
          ovl_flag <= ovl_flag | (|(accum & mask));
`endif
        end else begin
          ovf_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cluster_expander.sv
// tb/tb_cluster_expander.sv - scoreboard bench for cluster_expander
module tb_cluster_expander;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         frame_clock = 1'b0;
  logic         cluster_valid = 1'b0;
  logic [9:0]   cluster_adr = '0;
  logic [2:0]   cluster_cnt = '0;
  logic [767:0] vpfs_out;
  logic         vpfs_valid;
  logic         frame_overflow;
  logic [4:0]   frame_nclusters;
`ifdef CLUSTER_OVERLAP_DETECT_EN
  logic         overlap_err;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_strobes = 0;

  typedef struct {
    logic [767:0] bm;
    int           ncl;
    bit           ovf;
    bit           ovl;
    int           at;
  } exp_t;

  exp_t q[$];
  exp_t m;

  cluster_expander dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .frame_clock     (frame_clock),
    .cluster_valid   (cluster_valid),
    .cluster_adr     (cluster_adr),
    .cluster_cnt     (cluster_cnt),
    .vpfs_out        (vpfs_out),
    .vpfs_valid      (vpfs_valid),
    .frame_overflow  (frame_overflow),
`ifdef CLUSTER_OVERLAP_DETECT_EN
    .overlap_err     (overlap_err),
`endif
    .frame_nclusters (frame_nclusters)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [767:0] got, input logic [767:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic logic [767:0] rng(input logic [767:0] b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (i < 768) b[i] = 1'b1;
    return b;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.bm = '0; e.ncl = 0; e.ovf = 1'b0; e.ovl = 1'b0; e.at = 0;
    return e;
  endfunction

  task automatic step(input logic fc, input logic v, input int a, input int c);
    frame_clock   = fc;
    cluster_valid = v;
    cluster_adr   = 10'(a);
    cluster_cnt   = 3'(c);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0);
  endtask

  // Raise frame_clock this cycle; the strobe for the closing frame lands 3 cycles later.
  task automatic frame_end(input exp_t e, input logic v, input int a, input int c);
    e.at = cyc + 3;
    q.push_back(e);
    step(1'b1, v, a, c);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vpfs_out"}, vpfs_out, '0);
    chk({tag, "_vpfs_valid"}, 768'(vpfs_valid), '0);
    chk({tag, "_overflow"}, 768'(frame_overflow), '0);
    chk({tag, "_nclusters"}, 768'(frame_nclusters), '0);
  endtask

  always @(negedge clock) begin
    if (vpfs_valid) begin
      n_strobes++;
      if (q.size() == 0) begin
        chk("unexpected_strobe", 768'(1), 768'(0));
      end else begin
        m = q.pop_front();
        chk("latency", 768'(cyc), 768'(m.at));
        chk("vpfs_out", vpfs_out, m.bm);
        chk("nclusters", 768'(frame_nclusters), 768'(m.ncl));
        chk("overflow", 768'(frame_overflow), 768'(m.ovf));
`ifdef CLUSTER_OVERLAP_DETECT_EN
        chk("overlap_err", 768'(overlap_err), 768'(m.ovl));
`endif
      end
    end
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    idle(2);

    e = blank();
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    step(1'b0, 1'b1, 5, 2);
    idle(2);
    e = blank(); e.bm = rng(e.bm, 5, 7); e.ncl = 1;
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    step(1'b0, 1'b1, 62, 3);
    step(1'b0, 1'b1, 766, 7);
    e = blank(); e.bm = rng(e.bm, 62, 65); e.bm = rng(e.bm, 766, 767); e.ncl = 2;
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    // Cluster in the raise cycle closes the old frame; the one in the edge cycle opens the new one.
    e = blank(); e.bm = rng(e.bm, 200, 200); e.ncl = 1;
    frame_end(e, 1'b1, 200, 0);
    step(1'b0, 1'b1, 300, 1);
    idle(4);
    e = blank(); e.bm = rng(e.bm, 300, 301); e.ncl = 1;
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, i * 10, 0);
    e = blank(); e.ncl = 16; e.ovf = 1'b1;
    for (int i = 0; i < 16; i++) e.bm = rng(e.bm, i * 10, i * 10);
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    e = blank();
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    step(1'b0, 1'b1, 1023, 0);
    step(1'b0, 1'b1, 800, 5);
    e = blank();
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    step(1'b0, 1'b1, 20, 3);
    step(1'b0, 1'b1, 22, 0);
    e = blank(); e.bm = rng(e.bm, 20, 23); e.ncl = 2; e.ovl = 1'b1;
    frame_end(e, 1'b0, 0, 0);
    idle(5);

    step(1'b0, 1'b1, 100, 0);
    idle(1);
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("midreset");
    reset_n = 1'b1;
    step(1'b0, 1'b1, 40, 0);
    idle(1);
    e = blank(); e.bm = rng(e.bm, 40, 40); e.ncl = 1;
    frame_end(e, 1'b0, 0, 0);

    // frame_clock held low from here: no further strobes may appear.
    idle(20);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    chk("queue_drained", 768'(q.size()), 768'(0));
    chk("strobe_count", 768'(n_strobes), 768'(10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
